// File: rtl/tensor_core_pkg.sv
// Shared constants and the row-stream FSM state type for the tensor core
// banked register file and its row-stream loader.
package tensor_core_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_MATRIX_DIM = 4;

    typedef enum logic {
        STREAM_IDLE    = 1'b0,
        STREAM_LOADING = 1'b1
    } stream_state_t;

    // Index width with a floor of one bit so single-entry dimensions still get a real port.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/tensor_core_row_stream_loader.sv
// Row-stream loader: tracks which row of a matrix the next accepted beat
// fills, latches the target matrix on row 0, and pulses done one cycle after
// the last row is written. With MATRIX_DIM = 1 every beat is first and last.
module tensor_core_row_stream_loader
    import tensor_core_pkg::*;
#(
    parameter int MATRIX_DIM   = DEFAULT_MATRIX_DIM,
    parameter int SELECT_WIDTH = 1,
    parameter int ROW_WIDTH    = index_width(MATRIX_DIM)
) (
    input  logic                    clock_in,
    input  logic                    reset_n_in,
    input  logic                    beat_accept_in,
    input  logic [SELECT_WIDTH-1:0] matrix_select_in,
    output logic [ROW_WIDTH-1:0]    row_index_out,
    output logic [SELECT_WIDTH-1:0] matrix_select_out,
    output logic                    row_write_out,
    output logic                    loading_out,
    output logic                    done_out
);

    localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(MATRIX_DIM - 1);

    stream_state_t           state_q;
    stream_state_t           state_d;
    logic [ROW_WIDTH-1:0]    row_q;
    logic [ROW_WIDTH-1:0]    row_d;
    logic [SELECT_WIDTH-1:0] select_q;
    logic                    done_q;
    logic                    first_row;
    logic                    last_row;

    assign first_row = (row_q == '0);
    assign last_row  = (row_q == LAST_ROW);

    // Next state and next row: advance on every accepted beat, wrapping after the last row.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        if (beat_accept_in) begin
            row_d = last_row ? '0 : row_q + 1'b1;
            case (state_q)
                STREAM_IDLE:    if (!last_row) state_d = STREAM_LOADING;
                STREAM_LOADING: if (last_row)  state_d = STREAM_IDLE;
                default:        state_d = STREAM_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= STREAM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Row counter, matrix select latched on row 0, and the registered done pulse.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            row_q    <= '0;
            select_q <= '0;
            done_q   <= 1'b0;
        end else begin
            row_q  <= row_d;
            done_q <= beat_accept_in && last_row;
            if (beat_accept_in && first_row) begin
                select_q <= matrix_select_in;
            end
        end
    end

    assign row_index_out     = row_q;
    assign matrix_select_out = first_row ? matrix_select_in : select_q;
    assign row_write_out     = beat_accept_in;
    assign loading_out       = (state_q == STREAM_LOADING);
    assign done_out          = done_q;

endmodule

// File: rtl/tensor_core_banked_register_file.sv
// Banked register file holding NUMBER_OF_MATRICES square matrices, written by
// single-element, whole-file bulk, or row-stream writes (bulk > stream > single).
// Optional feature macro TENSOR_CORE_REGFILE_SHADOW_EN: writes land in a shadow
// bank that is committed to the visible bank on a swap request; a swap asked for
// mid-stream waits until the stream finishes.
module tensor_core_banked_register_file
    import tensor_core_pkg::*;
#(
    parameter  int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter  int MATRIX_DIM         = DEFAULT_MATRIX_DIM,
    parameter  int NUMBER_OF_MATRICES = 2,
    localparam int ADDRESS_WIDTH      = index_width(NUMBER_OF_MATRICES * MATRIX_DIM * MATRIX_DIM),
    localparam int SELECT_WIDTH       = index_width(NUMBER_OF_MATRICES)
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    input  logic                     single_write_enable_in,
    input  logic [ADDRESS_WIDTH-1:0] single_write_address_in,
    input  logic [DATA_WIDTH-1:0]    single_write_data_in,
    input  logic                     bulk_write_enable_in,
    input  logic [NUMBER_OF_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] bulk_write_data_in,
    input  logic                     stream_valid_in,
    output logic                     stream_ready_out,
    input  logic [SELECT_WIDTH-1:0]  stream_matrix_select_in,
    input  logic [MATRIX_DIM-1:0][DATA_WIDTH-1:0] stream_row_data_in,
    output logic                     stream_done_out,
    input  logic                     swap_request_in,
    output logic                     swap_done_out,
    output logic [NUMBER_OF_MATRICES-1:0][MATRIX_DIM-1:0][MATRIX_DIM-1:0][DATA_WIDTH-1:0] read_data_out
);

    localparam int ELEMENT_COUNT   = NUMBER_OF_MATRICES * MATRIX_DIM * MATRIX_DIM;
    localparam int BANK_WIDTH      = ELEMENT_COUNT * DATA_WIDTH;
    localparam int ROW_WIDTH       = MATRIX_DIM * DATA_WIDTH;
    localparam int ROW_INDEX_WIDTH = index_width(MATRIX_DIM);

    logic [BANK_WIDTH-1:0]      active_bank_q;
    logic [BANK_WIDTH-1:0]      write_bank;
    logic [BANK_WIDTH-1:0]      bank_next;
    logic [BANK_WIDTH-1:0]      bulk_flat;
    logic [ROW_WIDTH-1:0]       row_flat;
    logic                       commit_cycle;
    logic                       beat_accept;
    logic                       row_write;
    logic                       stream_loading;
    logic [ROW_INDEX_WIDTH-1:0] stream_row;
    logic [SELECT_WIDTH-1:0]    stream_matrix;
    int                         stream_row_slot;
    int                         single_slot;

    assign bulk_flat = bulk_write_data_in;
    assign row_flat  = stream_row_data_in;

    assign stream_ready_out = !bulk_write_enable_in && !commit_cycle;
    assign beat_accept      = stream_valid_in && stream_ready_out;

    tensor_core_row_stream_loader #(
        .MATRIX_DIM   (MATRIX_DIM),
        .SELECT_WIDTH (SELECT_WIDTH),
        .ROW_WIDTH    (ROW_INDEX_WIDTH)
    ) u_row_stream_loader (
        .clock_in          (clock_in),
        .reset_n_in        (reset_n_in),
        .beat_accept_in    (beat_accept),
        .matrix_select_in  (stream_matrix_select_in),
        .row_index_out     (stream_row),
        .matrix_select_out (stream_matrix),
        .row_write_out     (row_write),
        .loading_out       (stream_loading),
        .done_out          (stream_done_out)
    );

    assign stream_row_slot = int'(stream_matrix) * MATRIX_DIM + int'(stream_row);
    assign single_slot     = int'(single_write_address_in);

    // Merge this cycle's winning write into the target bank; out-of-range single addresses match no element.
    always_comb begin
        bank_next = write_bank;
        for (int e = 0; e < ELEMENT_COUNT; e++) begin
            if (bulk_write_enable_in) begin
                bank_next[e*DATA_WIDTH +: DATA_WIDTH] = bulk_flat[e*DATA_WIDTH +: DATA_WIDTH];
            end else if (row_write) begin
                if ((e / MATRIX_DIM) == stream_row_slot) begin
                    bank_next[e*DATA_WIDTH +: DATA_WIDTH] = row_flat[(e % MATRIX_DIM)*DATA_WIDTH +: DATA_WIDTH];
                end
            end else if (single_write_enable_in && (e == single_slot)) begin
                bank_next[e*DATA_WIDTH +: DATA_WIDTH] = single_write_data_in;
            end
        end
    end

`ifdef TENSOR_CORE_REGFILE_SHADOW_EN
    logic [BANK_WIDTH-1:0] shadow_bank_q;
    logic                  swap_pending_q;
    logic                  swap_done_q;

    assign commit_cycle  = (swap_request_in || swap_pending_q) && !stream_loading;
    assign write_bank    = shadow_bank_q;
    assign swap_done_out = swap_done_q;

    // Shadow takes every write; the active bank only changes when a commit copies the shadow across.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shadow_bank_q  <= '0;
            active_bank_q  <= '0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            shadow_bank_q  <= bank_next;
            swap_pending_q <= !commit_cycle && (swap_pending_q || swap_request_in);
            swap_done_q    <= commit_cycle;
            if (commit_cycle) begin
                active_bank_q <= shadow_bank_q;
            end
        end
    end
`else
    logic unused_swap_signals;

    assign unused_swap_signals = swap_request_in ^ stream_loading;
    assign commit_cycle        = 1'b0;
    assign write_bank          = active_bank_q;
    assign swap_done_out       = 1'b0;

    // Writes land directly in the visible bank.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            active_bank_q <= '0;
        end else begin
            active_bank_q <= bank_next;
        end
    end
`endif

    assign read_data_out = active_bank_q;

endmodule
